instruction_fetch_buffer: RTL and testbench
===========================================

Name: instruction_fetch_buffer

Overview:
- Fetch stage directly upstream of the combinational-read instruction memory.
- Owns the fetch PC and drives the word-aligned byte address to the memory. Captures the returned word together with its PC into a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Branch/jump redirects flush the FIFO and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 2, FIFO entries; power of two, legal range 2..8.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- redirect_valid  input  1  load redirect_pc and flush this cycle.
- redirect_pc  input  32  new fetch byte address.
- imem_addr  output  32  byte address to instruction memory.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- inst_pc  output  32  PC of the head instruction.
- inst_word  output  32  head instruction word.

Behaviour:
- Reset (async assert, sync release by the clock domain):
  - fetch_pc=RESET_PC.
  - FIFO empty, with count, rd_ptr and wr_ptr all 0.
  - inst_valid=0, inst_pc=0, inst_word=0.
  - imem_addr=RESET_PC.
  - Reset mid-operation discards all entries immediately.
- imem_addr=fetch_pc, driven straight from the register; no combinational path from any input. fetch_pc[1:0] is always 00.
- pop = inst_valid & inst_ready.
- push = (count<DEPTH | pop) & !redirect_valid.
  - On push: the entry {fetch_pc, imem_data} is written at wr_ptr.
  - fetch_pc <= fetch_pc+4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Full (count==DEPTH) with no pop: no push; fetch_pc holds.
- Full with pop: push and pop in the same cycle; count unchanged.
- Empty: inst_valid=0. inst_pc and inst_word hold their last values and are don't-care for verification.
- Latency:
  - An instruction at fetch_pc is visible on inst_* one cycle after its push edge.
  - Reset release or redirect gives first inst_valid=1 two edges later: the redirect/reset edge loads the PC, the next edge pushes.
  - Steady state: one instruction per cycle when inst_ready is held 1.
- Redirect:
  - On the edge with redirect_valid=1, count, rd_ptr and wr_ptr are cleared.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Redirect has priority over push and pop in the same cycle. A simultaneous pop still completes toward decode, because decode sampled a valid head; the FIFO state is cleared regardless.
  - inst_valid=0 the cycle after a redirect.
  - Back-to-back redirects: the last one wins; no pushes in between.
- count width is clog2(DEPTH)+1. Pointers are clog2(DEPTH) bits and wrap naturally.
- Outputs inst_* are registered from FIFO storage, not from imem_data.

Optional Feature:
- Macro: FETCH_MISALIGN_FLAG_EN.
- When defined:
  - Adds output port fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=00 sets fetch_misaligned=1 on that edge.
  - fetch_pc is loaded with redirect_pc[31:2],00 as usual, but push is inhibited while fetch_misaligned=1, so inst_valid stays 0.
  - The flag clears only on a redirect with aligned redirect_pc or on reset.
- When undefined:
  - No extra port.
  - Low two bits of redirect_pc are silently cleared and fetching proceeds normally.

Test Plan:
- Reset with RESET_PC=0, memory word[n]=n, inst_ready=1 -> imem_addr=0 during reset. After release, inst_valid rises on the 2nd edge with inst_pc=0, inst_word=0, then pc 4, 8, 12 with words 1, 2, 3 on consecutive cycles.
- inst_ready=0 for 5 cycles with DEPTH=2 -> FIFO fills after 2 pushes and imem_addr holds at 8. Head stays pc 0. Raising ready yields pc 0, 4, 8 with no gaps or duplicates.
- Redirect to 32'h0000_0100 while full and inst_ready=1 -> next cycle inst_valid=0. The following cycle inst_pc=0x100, inst_word=word[0x40]; no stale entry appears.
- Redirect to 32'hFFFF_FFF8, ready=1 -> output PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rst_n=0 asynchronously between edges with 2 entries queued -> inst_valid drops to 0 immediately, without waiting for an edge. After release, fetch restarts at RESET_PC.
- Redirect to 32'h0000_0102:
  - Without FETCH_MISALIGN_FLAG_EN: fetch resumes at 0x100.
  - With FETCH_MISALIGN_FLAG_EN: fetch_misaligned=1 and inst_valid stays 0 for 10 cycles. A redirect to 0x200 clears the flag and fetch resumes at 0x200.

Source files
------------

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: owns the fetch PC, drives the instruction memory address and queues
// {pc, word} pairs in a small prefetch FIFO presented to decode over valid/ready.
// Optional feature macro: FETCH_MISALIGN_FLAG_EN adds the fetch_misaligned output and
// stalls fetching after a redirect to a non-word-aligned address.
module instruction_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_word
`ifdef FETCH_MISALIGN_FLAG_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];
  logic          pop, push, stall;

`ifdef FETCH_MISALIGN_FLAG_EN
  logic misaligned_q, misaligned_d;

  // Any redirect re-evaluates the flag; otherwise it holds.
  always_comb begin
    misaligned_d = misaligned_q;
    if (redirect_valid) misaligned_d = (redirect_pc[1:0] != 2'b00);
  end

  // Misalignment flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end

  assign fetch_misaligned = misaligned_q;
  assign stall            = misaligned_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign stall               = 1'b0;
`endif

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_pc    = pc_mem[rd_ptr_q];
  assign inst_word  = word_mem[rd_ptr_q];

  assign pop  = inst_valid & inst_ready;
  assign push = ((count_q < DepthC) | pop) & ~redirect_valid & ~stall;

  // Next-state for PC, occupancy and pointers; a redirect overrides push and pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      word_mem[wr_ptr_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer (DEPTH=2, RESET_PC=0).
// Memory returns word[n] = n for byte address 4n.
module tb_instruction_fetch_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_word;
`ifdef FETCH_MISALIGN_FLAG_EN
  logic        fetch_misaligned;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of PCs held in the FIFO, next fetch PC, misalign flag.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_mis;

  always #5 clk = ~clk;

  assign imem_data = {2'b00, imem_addr[31:2]};

  instruction_fetch_buffer #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_pc       (inst_pc),
    .inst_word     (inst_word)
`ifdef FETCH_MISALIGN_FLAG_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_word;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc  = 32'h0;
    m_mis = 1'b0;
  endtask

  // Apply inputs at the falling edge, advance the model, and settle past the rising edge.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
    bit pop, push;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    pop  = (m_q.size() != 0) && rdy;
    push = ((m_q.size() < DEPTH) || pop) && !redir && !m_mis;
    if (redir) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_FLAG_EN
      m_mis = (rpc[1:0] != 2'b00);
`endif
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic exp_v;
    exp_v = (m_q.size() != 0);
    check({tag, " valid"}, {31'b0, inst_valid}, {31'b0, exp_v});
    check({tag, " addr"}, imem_addr, m_pc);
    if (exp_v) begin
      check({tag, " pc"}, inst_pc, m_q[0]);
      check({tag, " word"}, inst_word, m_q[0] >> 2);
    end
`ifdef FETCH_MISALIGN_FLAG_EN
    check({tag, " misaligned"}, {31'b0, fetch_misaligned}, {31'b0, m_mis});
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h0,         32'h4};
    tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h1,         32'h8};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h2,         32'hC};
    tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         32'h3,         32'h10};
    tbl[4]  = '{1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         32'h0};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0,         32'h4};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0,         32'h8};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0,         32'h8};
    tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0,         32'h8};
    tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0,         32'h8};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h1,         32'hC};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h2,         32'h10};
    tbl[12] = '{1'b1, 32'h100,       1'b1, 1'b0, 32'h0,         32'h0,         32'h100};
    tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       32'h40,        32'h104};
    tbl[14] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFF8};
    tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 32'h3FFF_FFFE, 32'hFFFF_FFFC};
    tbl[16] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0};
    tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h0,         32'h4};
    tbl[18] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h1,         32'h8};
    tbl[19] = '{1'b1, 32'h300,       1'b1, 1'b0, 32'h0,         32'h0,         32'h300};
    tbl[20] = '{1'b1, 32'h400,       1'b1, 1'b0, 32'h0,         32'h0,         32'h400};
    tbl[21] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h400,       32'h100,       32'h404};

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset addr", imem_addr, 32'h0);
    check("reset valid", {31'b0, inst_valid}, 32'h0);
    check("reset pc", inst_pc, 32'h0);
    check("reset word", inst_word, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    check("release valid", {31'b0, inst_valid}, 32'h0);

    // Directed table: fill/stall, redirects, address wrap, back-to-back redirects.
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      check($sformatf("v%0d valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].exp_valid});
      check($sformatf("v%0d addr", i), imem_addr, tbl[i].exp_addr);
      if (tbl[i].exp_valid) begin
        check($sformatf("v%0d pc", i), inst_pc, tbl[i].exp_pc);
        check($sformatf("v%0d word", i), inst_word, tbl[i].exp_word);
      end
    end

    // Asynchronous reset with two entries queued.
    step(1'b0, 32'h0, 1'b0);
    check_model("prefill");
    check("prefill valid", {31'b0, inst_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async valid", {31'b0, inst_valid}, 32'h0);
    check("async addr", imem_addr, 32'h0);
    model_reset();
    #1;
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    check("restart valid", {31'b0, inst_valid}, 32'h1);
    check("restart pc", inst_pc, 32'h0);
    check_model("restart");

    // Redirect to a misaligned address.
    step(1'b1, 32'h102, 1'b1);
    check("mis addr", imem_addr, 32'h100);
    check("mis valid", {31'b0, inst_valid}, 32'h0);
`ifdef FETCH_MISALIGN_FLAG_EN
    check("mis flag set", {31'b0, fetch_misaligned}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check($sformatf("mis stall%0d valid", i), {31'b0, inst_valid}, 32'h0);
      check($sformatf("mis stall%0d addr", i), imem_addr, 32'h100);
    end
    step(1'b1, 32'h200, 1'b1);
    check("mis flag clear", {31'b0, fetch_misaligned}, 32'h0);
    check("mis clear addr", imem_addr, 32'h200);
    step(1'b0, 32'h0, 1'b1);
    check("mis resume pc", inst_pc, 32'h200);
    check("mis resume word", inst_word, 32'h80);
`else
    step(1'b0, 32'h0, 1'b1);
    check("mis resume pc", inst_pc, 32'h100);
    check("mis resume word", inst_word, 32'h40);
`endif
    check_model("mis end");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic        redir;
      logic [31:0] rpc;
      redir = ($urandom_range(0, 11) == 0);
      rpc   = $urandom();
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step(redir, rpc, 1'($urandom_range(0, 1)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
